// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: PC owner and imem fetch sequencer feeding a 2-entry instruction FIFO to decode.
module rv_fetch_ctrl #(
   parameter int MEM_ADDR_WIDTH = 64,
   parameter int MEM_DATA_WIDTH = 32
) (
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
   output logic                      imem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [MEM_DATA_WIDTH-1:0] imem_data_i,
   input  logic                      imem_ack_i,
   input  logic                      redirect_i,
   input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                      inst_valid_o,
   output logic [MEM_DATA_WIDTH-1:0] inst_o,
   output logic [MEM_ADDR_WIDTH-1:0] inst_pc_o,
   input  logic                      inst_ready_i
);
   typedef enum logic {FETCH, DISCARD} state_t;
   state_t state, state_nx;
   logic run;
   logic [MEM_ADDR_WIDTH-1:0] pc, pc_nx, daddr, daddr_nx, e1_pc;
   logic [MEM_DATA_WIDTH-1:0] e1_inst;
   logic [1:0] count, count_nx;
   logic fire, push, pop, head_ld, e1_we;
   logic unused_lsbs;
   assign unused_lsbs = ^{redirect_pc_i[1:0], boot_addr_i[1:0]};
   // run holds req low for the first cycle after reset so the outputs read as reset values
   assign imem_req_o   = run & ((state == DISCARD) | (count < 2'd2));
   assign imem_addr_o  = !run ? '0 : (state == DISCARD) ? daddr : pc;
   assign inst_valid_o = count != 2'd0;
   assign fire    = imem_req_o & imem_ack_i;
   assign pop     = inst_valid_o & inst_ready_i;
   assign push    = fire & (state == FETCH) & ~redirect_i;
   assign head_ld = (push & ((count == 2'd0) | pop)) | (pop & (count == 2'd2));
   assign e1_we   = push & ~pop & (count == 2'd1);
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      daddr_nx = daddr;
      count_nx = redirect_i ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      if (redirect_i) begin
         pc_nx    = {redirect_pc_i[MEM_ADDR_WIDTH-1:2], 2'b00};
         state_nx = (imem_req_o & ~imem_ack_i) ? DISCARD : FETCH;
         daddr_nx = imem_addr_o;
      end else if (fire) begin
         state_nx = FETCH;
         pc_nx    = (state == FETCH) ? pc + MEM_ADDR_WIDTH'(4) : pc;
      end
   end
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state     <= FETCH;
         run       <= 1'b0;
         pc        <= {boot_addr_i[MEM_ADDR_WIDTH-1:2], 2'b00};
         daddr     <= '0;
         count     <= 2'd0;
         inst_o    <= '0;
         inst_pc_o <= '0;
         e1_inst   <= '0;
         e1_pc     <= '0;
      end else begin
         state <= state_nx;
         run   <= 1'b1;
         pc    <= pc_nx;
         daddr <= daddr_nx;
         count <= count_nx;
         if (head_ld) begin
            inst_o    <= (count == 2'd2) ? e1_inst : imem_data_i;
            inst_pc_o <= (count == 2'd2) ? e1_pc : pc;
         end
         if (e1_we) begin
            e1_inst <= imem_data_i;
            e1_pc   <= pc;
         end
      end
   end
   a_align: assert property (@(posedge clk_i) imem_addr_o[1:0] == 2'b00);
   a_stable: assert property (@(posedge clk_i) (!srst_i && imem_req_o && !imem_ack_i) |=> (srst_i || (imem_req_o && $stable(imem_addr_o))));
   a_count: assert property (@(posedge clk_i) count <= 2'd2);
   a_full: assert property (@(posedge clk_i) !(push && count == 2'd2));
endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb_rv_fetch_ctrl: scoreboard bench; a queue of expected {inst,pc} is built from fetch rules and checked at decode pops.
module tb_rv_fetch_ctrl;
   logic        clk_i = 1'b0;
   logic        srst_i = 1'b1;
   logic [63:0] boot_addr_i = '0;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic [31:0] imem_data_i = '0;
   logic        imem_ack_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [63:0] inst_pc_o;
   logic        inst_ready_i = 1'b0;

   rv_fetch_ctrl #(.MEM_ADDR_WIDTH(64), .MEM_DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .srst_i(srst_i), .boot_addr_i(boot_addr_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
      .imem_ack_i(imem_ack_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
      .inst_ready_i(inst_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   logic [95:0] sb[$];
   logic [63:0] exp_pc = '0;
   logic [63:0] stale_addr = '0;
   bit stale = 0;
   bit flush_pend = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the model decides what the coming edge must do.
   task automatic step(input bit ack, input bit rdy, input bit rd, input logic [63:0] rpc, input logic [31:0] d);
      bit exp_req;
      @(posedge clk_i); #1;
      if (flush_pend) begin
         sb.delete();
         flush_pend = 0;
      end
      imem_ack_i = ack; inst_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc; imem_data_i = d;
      exp_req = stale || sb.size() < 2;
      chk("req", {63'd0, imem_req_o}, {63'd0, exp_req});
      if (exp_req) chk("addr", imem_addr_o, stale ? stale_addr : exp_pc);
      if (rd) begin
         flush_pend = 1;
         if (exp_req && !ack) begin
            if (!stale) stale_addr = exp_pc;
            stale = 1;
         end else stale = 0;
         exp_pc = rpc & ~64'h3;
      end else if (exp_req && ack) begin
         if (stale) stale = 0;
         else begin
            sb.push_back({d, exp_pc});
            exp_pc = exp_pc + 64'd4;
         end
      end
   endtask

   task automatic do_reset(input logic [63:0] boot);
      @(posedge clk_i); #1;
      srst_i = 1; boot_addr_i = boot; imem_ack_i = 0; inst_ready_i = 0; redirect_i = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_i); #1;
         chk("rst_req", {63'd0, imem_req_o}, 64'd0);
         chk("rst_valid", {63'd0, inst_valid_o}, 64'd0);
         chk("rst_addr", imem_addr_o, 64'd0);
         chk("rst_inst", {32'd0, inst_o}, 64'd0);
         chk("rst_pc", inst_pc_o, 64'd0);
      end
      srst_i = 0;
      boot_addr_i = {$urandom, $urandom};
      sb.delete();
      flush_pend = 0;
      stale = 0;
      exp_pc = boot & ~64'h3;
      chk("rel_req", {63'd0, imem_req_o}, 64'd0);
   endtask

   always @(negedge clk_i) begin
      logic [95:0] e;
      if (!srst_i && inst_valid_o && inst_ready_i) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_empty: got inst=%h pc=%h want nothing", inst_o, inst_pc_o);
         end else begin
            e = sb.pop_front();
            chk("inst", {32'd0, inst_o}, {32'd0, e[95:64]});
            chk("inst_pc", inst_pc_o, e[63:0]);
         end
      end
   end

   initial begin
      do_reset(64'h8000_0000);
      for (int i = 0; i < 2; i++) step(1, 1, 0, '0, $urandom);
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, '0, $urandom);
         chk("stream_valid", {63'd0, inst_valid_o}, 64'd1);
      end
      do_reset(64'h0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, '0, $urandom);
      for (int i = 0; i < 4; i++) step(1, 1, 0, '0, $urandom);
      do_reset(64'h0);
      step(0, 1, 1, 64'h1002, '0);
      for (int i = 0; i < 2; i++) step(0, 1, 0, '0, '0);
      step(1, 1, 0, '0, 32'h1111_1111);
      for (int i = 0; i < 3; i++) step(1, 1, 0, '0, $urandom);
      step(1, 1, 1, 64'h2000, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) step(1, 1, 0, '0, $urandom);
      step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, $urandom);
      for (int i = 0; i < 4; i++) step(1, 1, 0, '0, $urandom);
      for (int i = 0; i < 4; i++) step(1, 0, 0, '0, $urandom);
      do_reset(64'h4000);
      for (int i = 0; i < 3; i++) step(1, 1, 0, '0, $urandom);
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
              {$urandom, $urandom}, $urandom);
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0);
      @(negedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
